// File: rtl/rom_burst_reader.sv
// Synchronous-read ROM with a burst read engine streaming words over valid/ready.
// A burst is launched by start in IDLE and may optionally wrap at the end of the table.
module rom_burst_reader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 11,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              wrap_en,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              oob_err,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              wrap_q, wrap_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              last_q, last_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] next_addr;
  logic              handshake;

  logic [DATA_W-1:0] rom [DEPTH];

  function automatic logic [DATA_W-1:0] builtin_word(input int unsigned i);
    if (i <= 8)       return DATA_W'(90 - 10 * i);
    else if (i == 9)  return DATA_W'(100);
    else if (i == 10) return DATA_W'(101);
    else              return '0;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) rom[i] = builtin_word(i);
  end

  // Out-of-range addresses read as zero rather than indexing past the table.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) w = rom[i];
    end
    return w;
  endfunction

  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W + 1)'(DEPTH);
  endfunction

  assign handshake = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
      oob_q   <= oob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (length != '0) ? READ : FIN;
      READ: state_d = HOLD;
      HOLD: if (handshake && last_q) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In HOLD the next word is read on the same edge that retires the current beat,
  // so a consumer holding out_ready high sees one word per cycle.
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    valid_d = valid_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    last_d  = last_q;
    oob_d   = oob_q;
    busy    = (state_q == READ) || (state_q == HOLD);
    done    = (state_q == FIN);

    if (wrap_q && (addr_q == ADDR_W'(DEPTH - 1))) next_addr = '0;
    else                                          next_addr = addr_q + ADDR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = length;
          wrap_d = wrap_en;
          oob_d  = 1'b0;
        end
      end
      READ: begin
        data_d  = rom_word(addr_q);
        oaddr_d = addr_q;
        last_d  = (rem_q == ADDR_W'(1));
        valid_d = 1'b1;
        if (is_oob(addr_q)) oob_d = 1'b1;
      end
      HOLD: begin
        if (handshake) begin
          if (last_q) begin
            valid_d = 1'b0;
          end else begin
            rem_d   = rem_q - ADDR_W'(1);
            addr_d  = next_addr;
            data_d  = rom_word(next_addr);
            oaddr_d = next_addr;
            last_d  = (rem_q == ADDR_W'(2));
            if (is_oob(next_addr)) oob_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = oaddr_q;
  assign out_last  = last_q;
  assign oob_err   = oob_q;

endmodule
